// File: rtl/sym_packer_pkg.sv
// rtl/sym_packer_pkg.sv - shared widths and helpers for the symbol packer
package sym_packer_pkg;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

    localparam int DEF_SYM_W = 2;
    localparam int DEF_SYMS  = 4;
    localparam int DEF_CNT_W = 16;

    localparam int WORD_W = DEF_SYM_W * DEF_SYMS;
    localparam int IDX_W  = clog2(DEF_SYMS);
    localparam int OCNT_W = IDX_W + 1;

endpackage

// File: rtl/sym_out_reg.sv
// rtl/sym_out_reg.sv - output holding register with valid/ready and transfer counter
module sym_out_reg #(
    parameter int WW    = 8,
    parameter int OW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WW-1:0]    load_word,
    input  logic [OW-1:0]    load_cnt,
    input  logic             out_ready,
    output logic [WW-1:0]    out_word,
    output logic [OW-1:0]    out_cnt,
    output logic             out_valid,
    output logic [CNT_W-1:0] words_sent
);

    logic xfer;

    assign xfer = out_valid && out_ready;

    // The parent only asserts load when the slot is free, so a reload
    // never overwrites a word that has not been taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_word   <= '0;
            out_cnt    <= '0;
            out_valid  <= 1'b0;
            words_sent <= '0;
        end else begin
            if (load) begin
                out_word  <= load_word;
                out_cnt   <= load_cnt;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            if (xfer) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sym_packer.sv
// rtl/sym_packer.sv - packs 2-bit symbols LSB-first into words with flush support
module sym_packer
    import sym_packer_pkg::*;
#(
    parameter int SYM_W = DEF_SYM_W,
    parameter int SYMS  = DEF_SYMS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SYM_W-1:0]            in_sym,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [SYM_W*SYMS-1:0]       out_word,
    output logic [clog2(SYMS):0]        out_cnt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            words_sent
);

    localparam int WW = SYM_W * SYMS;
    localparam int IW = clog2(SYMS);
    localparam int OW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(SYMS - 1);

    logic [WW-1:0] acc;
    logic [WW-1:0] acc_merged;
    logic [IW-1:0] idx;
    logic          flush_pend;
    logic          slot_free;
    logic          in_xfer;
    logic          complete;
    logic          flush_go;
    logic          load;
    logic [WW-1:0] load_word;
    logic [OW-1:0] load_cnt;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !flush_pend && ((idx != LAST) || slot_free);
    assign in_xfer   = in_valid && in_ready;
    assign complete  = in_xfer && (idx == LAST);
    assign flush_go  = flush_pend && slot_free;

    always_comb begin
        acc_merged = acc;
        acc_merged[idx*SYM_W +: SYM_W] = in_sym;
    end

    // A pending flush blocks input, so completion and flush service never coincide.
    assign load      = complete || (flush_go && (idx != '0));
    assign load_word = complete ? acc_merged : acc;
    assign load_cnt  = complete ? OW'(SYMS) : OW'(idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            idx        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (complete || flush_go) begin
                acc <= '0;
                idx <= '0;
            end else if (in_xfer) begin
                acc <= acc_merged;
                idx <= idx + 1'b1;
            end
            if (flush_pend) begin
                if (slot_free) begin
                    flush_pend <= 1'b0;
                end
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    sym_out_reg #(
        .WW    (WW),
        .OW    (OW),
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_word  (load_word),
        .load_cnt   (load_cnt),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .words_sent (words_sent)
    );

endmodule

// File: tb/tb_sym_packer.sv
// tb/tb_sym_packer.sv - scoreboard bench for sym_packer with a queue-based reference model
module tb_sym_packer;

    localparam int SYMS = 4;

    typedef struct {
        logic [7:0] word;
        int         cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  in_sym;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [7:0]  out_word;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] words_sent;

    int n_tests;
    int n_fail;

    logic [1:0] m_buf[$];
    exp_t       exp_q[$];
    logic       m_pend;
    int         m_sent;

    sym_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_sym     (in_sym),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_word   (out_word),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic emit_buf();
        exp_t e;
        e.word = 8'h00;
        e.cnt  = m_buf.size();
        for (int k = 0; k < m_buf.size(); k++) begin
            e.word = e.word | (8'(m_buf[k]) << (2 * k));
        end
        exp_q.push_back(e);
        m_buf.delete();
    endtask

    // Drive one cycle of inputs and advance the model by the coming edge.
    task automatic step(input logic v, input logic [1:0] s, input logic f, input logic r,
                        output logic taken);
        logic exp_rdy;
        logic free;
        @(negedge clk);
        in_valid  = v;
        in_sym    = s;
        flush     = f;
        out_ready = r;
        #1;
        free    = !out_valid || r;
        exp_rdy = !m_pend && ((m_buf.size() != SYMS - 1) || free);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        taken = v && in_ready;
        if (taken) begin
            m_buf.push_back(s);
            if (m_buf.size() == SYMS) emit_buf();
        end
        if (m_pend) begin
            if (free) m_pend = 1'b0;
        end else if (f) begin
            m_pend = 1'b1;
            if (m_buf.size() > 0) emit_buf();
        end
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b1, t);
    endtask

    task automatic send(input logic [1:0] s, input logic r);
        logic t;
        int   tries;
        tries = 0;
        t     = 1'b0;
        while (!t && tries < 20) begin
            step(1'b1, s, 1'b0, r, t);
            tries++;
        end
        if (!t) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got not accepted expected accepted");
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_buf.delete();
        exp_q.delete();
        m_pend = 1'b0;
        m_sent = 0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", out_word);
            end else begin
                e = exp_q.pop_front();
                chk("out_word", 32'(out_word), 32'(e.word));
                chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
            end
            m_sent++;
        end
    end

    initial begin
        logic t;
        n_tests   = 0;
        n_fail    = 0;
        m_pend    = 1'b0;
        m_sent    = 0;
        rst       = 1'b0;
        in_sym    = 2'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        do_reset(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_words_sent", 32'(words_sent), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_word", 32'(out_word), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);

        send(2'd1, 1'b1);
        send(2'd2, 1'b1);
        send(2'd3, 1'b1);
        send(2'd0, 1'b1);
        after_edge();
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_word", 32'(out_word), 32'h39);
        chk("full_cnt", 32'(out_cnt), 32'd4);
        idle(1);
        after_edge();
        chk("full_sent", 32'(words_sent), 32'd1);

        for (int i = 0; i < 7; i++) send(2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd3, 1'b0, 1'b0, t);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_hold_word", 32'(out_word), 32'hFF);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        send(2'd3, 1'b1);
        idle(2);
        after_edge();
        chk("bp_sent", 32'(words_sent), 32'd3);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        send(2'd2, 1'b1);
        send(2'd1, 1'b1);
        step(1'b0, 2'd0, 1'b1, 1'b1, t);
        after_edge();
        chk("pf_pending_ready", 32'(in_ready), 32'd0);
        step(1'b0, 2'd0, 1'b0, 1'b1, t);
        after_edge();
        chk("pf_valid", 32'(out_valid), 32'd1);
        chk("pf_word", 32'(out_word), 32'h06);
        chk("pf_cnt", 32'(out_cnt), 32'd2);
        idle(1);
        after_edge();
        chk("pf_ready_back", 32'(in_ready), 32'd1);

        step(1'b0, 2'd0, 1'b1, 1'b1, t);
        idle(2);
        after_edge();
        chk("ef_no_word", 32'(out_valid), 32'd0);

        send(2'd1, 1'b1);
        send(2'd1, 1'b1);
        send(2'd1, 1'b1);
        step(1'b1, 2'd2, 1'b1, 1'b1, t);
        after_edge();
        chk("cf_valid", 32'(out_valid), 32'd1);
        chk("cf_cnt", 32'(out_cnt), 32'd4);
        chk("cf_word", 32'(out_word), 32'h95);
        idle(1);
        after_edge();
        chk("cf_no_extra", 32'(out_valid), 32'd0);
        idle(2);
        chk("cf_sent", 32'(words_sent), 32'(m_sent));

        send(2'd3, 1'b1);
        send(2'd2, 1'b1);
        do_reset(2);
        idle(3);
        after_edge();
        chk("rm_no_word", 32'(out_valid), 32'd0);
        chk("rm_sent", 32'(words_sent), 32'd0);
        send(2'd0, 1'b1);
        send(2'd1, 1'b1);
        send(2'd2, 1'b1);
        send(2'd3, 1'b1);
        after_edge();
        chk("rm_word", 32'(out_word), 32'hE4);
        chk("rm_cnt", 32'(out_cnt), 32'd4);
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 t);
        end
        step(1'b0, 2'd0, 1'b1, 1'b1, t);
        idle(6);
        after_edge();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_sent", 32'(words_sent), 32'(m_sent & 32'hFFFF));
        chk("rand_idle_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sym_packer.md
Name: sym_packer

Overview:
- Downstream consumer of the 2-bit code stream produced by the registered counter/code stage.
- Accepts 2-bit symbols over a valid/ready handshake.
- Packs SYMS symbols LSB-first into one word. Emits each word with a symbol count over a second valid/ready handshake.
- A flush request forces out a partially filled word, zero-padded.

Parameters:
- SYM_W, 2, width of one input symbol.
- SYMS, 4, symbols per output word (>=2). Word width = SYM_W*SYMS.
- CNT_W, 16, width of the emitted-word statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- in_sym  input  SYM_W  symbol to pack.
- in_valid  input  1  in_sym is valid.
- in_ready  output  1  block accepts in_sym this cycle.
- flush  input  1  single-cycle request to emit the partial word.
- out_word  output  SYM_W*SYMS  packed word; symbol k sits at bits [k*SYM_W +: SYM_W].
- out_cnt  output  clog2(SYMS)+1  number of valid symbols in out_word (1..SYMS).
- out_valid  output  1  out_word/out_cnt are valid.
- out_ready  input  1  downstream takes the word this cycle.
- words_sent  output  CNT_W  count of words transferred (out_valid & out_ready).

Behaviour:
- Reset is asynchronous, active-low, on rst; clock is clk.
- Reset values:
  - out_valid=0, out_word=0, out_cnt=0, words_sent=0.
  - Internal accumulator=0, index idx=0, flush_pend=0.
  - in_ready settles to 1.
- Input transfer: in_valid & in_ready at a rising edge.
  - acc[idx*SYM_W +: SYM_W] <= in_sym; idx <= idx+1.
- Output transfer: out_valid & out_ready at a rising edge.
  - words_sent increments and wraps modulo 2^CNT_W.
- Slot free: slot_free = !out_valid | out_ready. Combinational; the out_ready->in_ready path is allowed.
- in_ready = !flush_pend & ((idx != SYMS-1) | slot_free).
- Word complete: input transfer with idx==SYMS-1, in the same cycle.
  - out_word <= acc with the new symbol merged; out_cnt <= SYMS; out_valid <= 1.
  - idx <= 0; acc <= 0.
- Latency: the last symbol accepted at edge N appears on out_word with out_valid=1 after edge N (one cycle).
- Output register holds out_word/out_cnt stable while out_valid & !out_ready.
  - Cleared to out_valid=0 on transfer unless reloaded in the same edge.
  - Back-to-back words at full rate are supported: transfer and reload in the same edge.
- flush=1 sets flush_pend at the next edge. While flush_pend=1, in_ready=0.
- Same-cycle symbol and flush: a symbol accepted in the same cycle as flush is included before the flush takes effect.
- Same-cycle completion and flush: if that symbol completes a word, the full word is emitted normally and the flush then finds idx=0.
- Flush service: when flush_pend & slot_free at an edge:
  - If idx>0: out_word <= acc (unfilled symbols 0), out_cnt <= idx, out_valid <= 1, idx <= 0, acc <= 0.
  - If idx==0: no word emitted.
  - Either case: flush_pend <= 0.
- Flush while pending is a no-op; requests do not queue.
- in_valid=0 and flush=0: state holds; no spurious output.
- Reset mid-operation: the partial word, any pending word and flush_pend are discarded; nothing is emitted after release.
- No internal combinational loops; all state is in clk-edge flops.

Decomposition:
- Shared package holds:
  - localparam WORD_W = SYM_W*SYMS.
  - localparam IDX_W = clog2(SYMS).
  - localparam OCNT_W = IDX_W+1.
  - A clog2 constant function.
- One natural sub-module, sym_out_reg: output holding register with valid/ready, load, hold and clear, plus the words_sent counter.
- Accumulator, index and flush control stay in sym_packer.

Test Plan:
- Reset values: hold rst=0 for 3 cycles, then release -> out_valid=0, words_sent=0, in_ready=1.
- Full word: out_ready=1; send symbols 1,2,3,0 on consecutive cycles -> one cycle after the 4th, out_word=8'h39, out_cnt=4, out_valid=1; words_sent=1 after transfer.
- Backpressure: out_ready=0; send 8 symbols all =3.
  - First word 8'hFF held stable; in_ready drops after symbol 7 with idx==3.
  - Raise out_ready -> words 8'hFF, 8'hFF transferred in order; no loss, no duplicate; words_sent=2.
- Partial flush: send 2,1, then pulse flush -> out_word=8'h06, out_cnt=2. in_ready=0 for the pending cycle; idx returns to 0.
- Flush with empty accumulator, and flush in the same cycle as the 4th symbol -> exactly one word with out_cnt=4, no extra word.
- Reset mid-word: send 2 symbols, assert rst, release -> no word emitted. The next 4 symbols 0,1,2,3 give out_word=8'hE4.
